// File: rtl/muldiv_sched.sv
// muldiv_sched: shares one 33-bit divider and one 33-bit multiplier between
// two requesters. Round-robin arbitration, operand forming, result slicing,
// id tagging and flush/kill handling.
// Optional build macro: MULDIV_FASTPATH_EN (divide-by-zero and multiply-by-zero
// results produced directly in ISSUE without starting a unit).
module muldiv_sched #(
  parameter int ID_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  input  logic [1:0][2:0]      req_op,
  input  logic [1:0][31:0]     req_op1,
  input  logic [1:0][31:0]     req_op2,
  input  logic [1:0][ID_W-1:0] req_id,
  output logic [1:0]           req_grant,
  input  logic [1:0]           flush,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [31:0]          resp_result,
  output logic [ID_W-1:0]      resp_id,
  output logic                 div_start,
  output logic                 div_signed,
  output logic [32:0]          div_dividend,
  output logic [32:0]          div_divisor,
  input  logic                 div_ready,
  input  logic                 div_valid,
  input  logic [32:0]          div_quotient,
  input  logic [32:0]          div_remainder,
  output logic                 mul_start,
  output logic                 mul_signed,
  output logic [32:0]          mul_multiplicand,
  output logic [32:0]          mul_multiplier,
  input  logic                 mul_ready,
  input  logic                 mul_valid,
  input  logic [65:0]          mul_product,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_reg, state_next;
  logic            rr_ptr_reg;
  logic            killed_reg;
  logic            owner_reg;
  logic [2:0]      op_reg;
  logic [31:0]     op1_reg, op2_reg, result_reg;
  logic [ID_W-1:0] id_reg;

  logic [1:0]  eligible;
  logic        accept;
  logic        is_div;
  logic        owner_flush;
  logic        unit_ready, unit_valid;
  logic        fast_hit;
  logic [31:0] fast_result;
  logic [31:0] unit_result;
  logic        issue_start;
  logic        op_active;
  logic        sext_div, sext_mcand, sext_mplier;

  // Upper result bits never reach the 32-bit response.
  logic unused_bits;
  assign unused_bits = &{1'b0, mul_product[65:64], div_quotient[32], div_remainder[32]};

  assign is_div      = op_reg[2];
  assign owner_flush = flush[owner_reg];
  assign unit_ready  = is_div ? div_ready : mul_ready;
  assign unit_valid  = is_div ? div_valid : mul_valid;
  assign eligible    = req_valid & ~flush;
  assign accept      = |req_grant;

`ifdef MULDIV_FASTPATH_EN
  // Trivial results: x/0 and x*0 need no unit.
  assign fast_hit    = is_div ? (op2_reg == 32'd0) : ((op1_reg == 32'd0) || (op2_reg == 32'd0));
  assign fast_result = is_div ? (op_reg[1] ? op1_reg : 32'hFFFF_FFFF) : 32'd0;
`else
  assign fast_hit    = 1'b0;
  assign fast_result = 32'd0;
`endif

  // Round-robin grant, only offered while idle; a flushed requester is skipped.
  always_comb begin
    req_grant = 2'b00;
    if (state_reg == IDLE) begin
      case (eligible)
        2'b01, 2'b10: req_grant = eligible;
        2'b11:        req_grant = rr_ptr_reg ? 2'b10 : 2'b01;
        default:      req_grant = 2'b00;
      endcase
    end
  end

  // Pick the 32-bit slice of the unit output that the op asks for.
  always_comb begin
    unit_result = 32'd0;
    case (op_reg)
      3'd0:             unit_result = mul_product[31:0];
      3'd1, 3'd2, 3'd3: unit_result = mul_product[63:32];
      3'd4, 3'd5:       unit_result = div_quotient[31:0];
      default:          unit_result = div_remainder[31:0];
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (accept) state_next = ISSUE;
      ISSUE: begin
        if (owner_flush)     state_next = IDLE;
        else if (fast_hit)   state_next = DONE;
        else if (unit_ready) state_next = WAIT;
      end
      WAIT:  if (unit_valid) state_next = (killed_reg || owner_flush) ? IDLE : DONE;
      DONE:  if (owner_flush || resp_ready[owner_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: unit control, operands and response.
  always_comb begin
    issue_start      = (state_reg == ISSUE) && !owner_flush && !fast_hit && unit_ready;
    op_active        = (state_reg == ISSUE) || (state_reg == WAIT);
    sext_div         = (op_reg == 3'd4) || (op_reg == 3'd6);
    sext_mcand       = (op_reg == 3'd0) || (op_reg == 3'd1) || (op_reg == 3'd2);
    sext_mplier      = (op_reg == 3'd0) || (op_reg == 3'd1);
    div_start        = issue_start && is_div;
    mul_start        = issue_start && !is_div;
    div_signed       = op_active && sext_div;
    mul_signed       = op_active && sext_mcand;
    div_dividend     = 33'd0;
    div_divisor      = 33'd0;
    mul_multiplicand = 33'd0;
    mul_multiplier   = 33'd0;
    if (op_active) begin
      div_dividend     = {sext_div & op1_reg[31], op1_reg};
      div_divisor      = {sext_div & op2_reg[31], op2_reg};
      mul_multiplicand = {sext_mcand & op1_reg[31], op1_reg};
      mul_multiplier   = {sext_mplier & op2_reg[31], op2_reg};
    end
    resp_result = (state_reg == DONE) ? result_reg : 32'd0;
    resp_id     = (state_reg == DONE) ? id_reg : '0;
    busy        = (state_reg != IDLE);
  end

  // Per-requester response valid; a flush in DONE drops it at once.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      assign resp_valid[gi] = (state_reg == DONE) && (owner_reg == gi[0]) && !owner_flush;
    end
  endgenerate

  // Request capture, round-robin pointer, kill flag and result latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg <= 1'b0;
      killed_reg <= 1'b0;
      owner_reg  <= 1'b0;
      op_reg     <= 3'd0;
      op1_reg    <= 32'd0;
      op2_reg    <= 32'd0;
      id_reg     <= '0;
      result_reg <= 32'd0;
    end else begin
      if (accept) begin
        owner_reg  <= req_grant[1];
        rr_ptr_reg <= ~req_grant[1];
        op_reg     <= req_op[req_grant[1]];
        op1_reg    <= req_op1[req_grant[1]];
        op2_reg    <= req_op2[req_grant[1]];
        id_reg     <= req_id[req_grant[1]];
        killed_reg <= 1'b0;
      end
      if (state_reg == ISSUE && fast_hit && !owner_flush)
        result_reg <= fast_result;
      if (state_reg == WAIT) begin
        if (owner_flush)
          killed_reg <= 1'b1;
        if (unit_valid) begin
          result_reg <= unit_result;
          killed_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed testbench for muldiv_sched with behavioural divider/multiplier models.
module tb_muldiv_sched;
  localparam int ID_W    = 64;
  localparam int DIV_LAT = 6;
  localparam int MUL_LAT = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           req_valid;
  logic [1:0][2:0]      req_op;
  logic [1:0][31:0]     req_op1, req_op2;
  logic [1:0][ID_W-1:0] req_id;
  logic [1:0]           req_grant;
  logic [1:0]           flush;
  logic [1:0]           resp_valid;
  logic [1:0]           resp_ready;
  logic [31:0]          resp_result;
  logic [ID_W-1:0]      resp_id;
  logic                 div_start, div_signed, div_ready, div_valid;
  logic [32:0]          div_dividend, div_divisor, div_quotient, div_remainder;
  logic                 mul_start, mul_signed, mul_ready, mul_valid;
  logic [32:0]          mul_multiplicand, mul_multiplier;
  logic [65:0]          mul_product;
  logic                 busy;

  always #5 clk = ~clk;

  muldiv_sched #(.ID_W(ID_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_op1(req_op1), .req_op2(req_op2),
    .req_id(req_id), .req_grant(req_grant), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_id(resp_id),
    .div_start(div_start), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_ready(div_ready), .div_valid(div_valid),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .mul_start(mul_start), .mul_signed(mul_signed),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_ready(mul_ready), .mul_valid(mul_valid), .mul_product(mul_product),
    .busy(busy)
  );

  // Behavioural 33-bit divider: never reset, fixed latency, x/0 -> all ones / dividend.
  logic              dbusy = 1'b0;
  int                dcnt = 0;
  logic signed [32:0] dq, dr;
  assign div_ready = !dbusy;
  initial begin div_valid = 1'b0; div_quotient = '0; div_remainder = '0; end
  always @(posedge clk) begin
    div_valid <= 1'b0;
    if (dbusy) begin
      if (dcnt == 1) begin
        div_valid <= 1'b1; dbusy <= 1'b0;
        div_quotient <= dq; div_remainder <= dr;
      end
      dcnt <= dcnt - 1;
    end else if (div_start) begin
      dbusy <= 1'b1; dcnt <= DIV_LAT;
      if (div_divisor == 33'd0) begin
        dq <= '1; dr <= div_dividend;
      end else begin
        dq <= $signed(div_dividend) / $signed(div_divisor);
        dr <= $signed(div_dividend) % $signed(div_divisor);
      end
    end
  end

  // Behavioural 33x33 signed multiplier.
  logic               mbusy = 1'b0;
  int                 mcnt = 0;
  logic signed [65:0] ma, mb, mp;
  assign mul_ready = !mbusy;
  initial begin mul_valid = 1'b0; mul_product = '0; end
  always @(posedge clk) begin
    mul_valid <= 1'b0;
    if (mbusy) begin
      if (mcnt == 1) begin
        mul_valid <= 1'b1; mbusy <= 1'b0; mul_product <= mp;
      end
      mcnt <= mcnt - 1;
    end else if (mul_start) begin
      mbusy <= 1'b1; mcnt <= MUL_LAT;
      ma = {{33{mul_multiplicand[32]}}, mul_multiplicand};
      mb = {{33{mul_multiplier[32]}}, mul_multiplier};
      mp <= ma * mb;
    end
  end

  // Start monitors.
  int   div_starts = 0, mul_starts = 0, proto_err = 0;
  logic last_mul_signed = 1'b0;
  always @(posedge clk) begin
    if (div_start) begin div_starts++; if (!div_ready) proto_err++; end
    if (mul_start) begin mul_starts++; if (!mul_ready) proto_err++; last_mul_signed <= mul_signed; end
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, {busy, req_grant, resp_valid, div_start, div_signed, mul_start, mul_signed}, 0);
    check({tag, "_data"}, |{div_dividend, div_divisor, mul_multiplicand, mul_multiplier, resp_result, resp_id}, 0);
  endtask

  // One request on requester r; resp_ready held low for 'hold' cycles after resp_valid.
  task automatic run_op(input string tag, input int r, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [63:0] id,
                        input logic [31:0] exp, input int hold);
    int n;
    @(negedge clk);
    req_valid[r] = 1'b1; req_op[r] = op; req_op1[r] = a; req_op2[r] = b; req_id[r] = id;
    #1;
    n = 0;
    while (!req_grant[r] && n < 50) begin @(negedge clk); #1; n++; end
    check({tag, "_grant"}, n < 50, 1);
    @(negedge clk);
    req_valid[r] = 1'b0;
    #1;
    n = 0;
    while (!resp_valid[r] && n < 200) begin @(negedge clk); #1; n++; end
    check({tag, "_resp"}, n < 200, 1);
    check({tag, "_result"}, resp_result, exp);
    check({tag, "_id"}, resp_id, id);
    $display("txn %s req%0d op%0d a=%h b=%h result=%h id=%h", tag, r, op, a, b, resp_result, resp_id);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      check({tag, "_hold_valid"}, resp_valid[r], 1);
      check({tag, "_hold_result"}, resp_result, exp);
    end
    resp_ready[r] = 1'b1;
    @(negedge clk);
    resp_ready[r] = 1'b0;
    #1;
    check({tag, "_release"}, resp_valid[r], 0);
  endtask

  // Round-robin stimulus tables.
  logic [2:0]  t_op0 [4] = '{3'd0, 3'd5, 3'd6, 3'd3};
  logic [31:0] t_a0  [4] = '{32'd3, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000};
  logic [31:0] t_b0  [4] = '{32'd5, 32'd7, 32'd2, 32'd4};
  logic [31:0] t_e0  [4] = '{32'd15, 32'd14, 32'hFFFF_FFFF, 32'd2};
  logic [2:0]  t_op1 [4] = '{3'd4, 3'd7, 3'd1, 3'd0};
  logic [31:0] t_a1  [4] = '{32'hFFFF_FFEC, 32'd100, 32'hFFFF_FFFF, 32'h1234_5678};
  logic [31:0] t_b1  [4] = '{32'd3, 32'd7, 32'hFFFF_FFFF, 32'd2};
  logic [31:0] t_e1  [4] = '{32'hFFFF_FFFA, 32'd2, 32'd0, 32'h2468_ACF0};

  initial begin
    int ms0, ds0, n, i0, i1, r0, r1, g;
    logic saw_dv, saw_resp;
    reset = 1'b1; req_valid = '0; req_op = '0; req_op1 = '0; req_op2 = '0; req_id = '0;
    flush = '0; resp_ready = '0;
    repeat (2) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk); reset = 1'b0;

    // Signed MUL with held response.
    ms0 = mul_starts;
    run_op("mul", 0, 3'd0, 32'd7, 32'hFFFF_FFFD, 64'hA5A5_0000_0000_0001, 32'hFFFF_FFEB, 2);
    check("mul_start_count", mul_starts - ms0, 1);
    check("mul_signed", last_mul_signed, 1);

    // Operand-extension and division boundaries.
    run_op("mulhsu", 1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h11, 32'hFFFF_FFFF, 0);
    run_op("mulhu",  1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h12, 32'hFFFF_FFFE, 0);
    run_op("div_ovf", 0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 64'h13, 32'h8000_0000, 0);
    run_op("divu_z", 1, 3'd5, 32'd5, 32'd0, 64'h14, 32'hFFFF_FFFF, 0);
    ds0 = div_starts;
    run_op("remu_z", 0, 3'd7, 32'd5, 32'd0, 64'h15, 32'd5, 0);
`ifdef MULDIV_FASTPATH_EN
    check("remu_z_starts", div_starts - ds0, 0);
`else
    check("remu_z_starts", div_starts - ds0, 1);
`endif

    // Flush the owner two cycles after div_start.
    ds0 = div_starts;
    @(negedge clk);
    req_valid[0] = 1'b1; req_op[0] = 3'd4; req_op1[0] = 32'd100; req_op2[0] = 32'd7; req_id[0] = 64'h20;
    #1;
    n = 0;
    while (!req_grant[0] && n < 50) begin @(negedge clk); #1; n++; end
    @(negedge clk); req_valid[0] = 1'b0;
    n = 0;
    while (div_starts == ds0 && n < 50) begin @(negedge clk); n++; end
    check("flush_started", div_starts - ds0, 1);
    @(negedge clk); flush[0] = 1'b1;
    @(negedge clk); flush[0] = 1'b0;
    #1;
    saw_dv = 1'b0; saw_resp = 1'b0; n = 0;
    check("flush_busy", busy, 1);
    while (busy && n < 100) begin
      if (div_valid) saw_dv = 1'b1;
      if (resp_valid[0]) saw_resp = 1'b1;
      @(negedge clk); #1; n++;
    end
    check("flush_idle", n < 100, 1);
    check("flush_busy_until_valid", saw_dv, 1);
    check("flush_no_resp", saw_resp, 0);
    run_op("after_flush", 1, 3'd0, 32'd6, 32'd7, 64'h21, 32'd42, 0);

    // Reset while waiting on the divider.
    ds0 = div_starts;
    @(negedge clk);
    req_valid[0] = 1'b1; req_op[0] = 3'd5; req_op1[0] = 32'd1000; req_op2[0] = 32'd10; req_id[0] = 64'h30;
    #1;
    n = 0;
    while (!req_grant[0] && n < 50) begin @(negedge clk); #1; n++; end
    @(negedge clk); req_valid[0] = 1'b0;
    n = 0;
    while (div_starts == ds0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk); #1;
    check("wait_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    @(negedge clk); reset = 1'b0;
    run_op("after_reset", 0, 3'd5, 32'd81, 32'd9, 64'h31, 32'd9, 0);
    check("reset_start_count", div_starts - ds0, 2);
    check("start_while_unready", proto_err, 0);

    // Both requesters valid every cycle: grants alternate starting at 0.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    i0 = 0; i1 = 0; r0 = 0; r1 = 0; g = 0; n = 0;
    resp_ready = 2'b11;
    while ((r0 < 4 || r1 < 4) && n < 3000) begin
      @(negedge clk);
      req_valid[0] = (i0 < 4);
      req_valid[1] = (i1 < 4);
      if (i0 < 4) begin
        req_op[0] = t_op0[i0]; req_op1[0] = t_a0[i0]; req_op2[0] = t_b0[i0]; req_id[0] = 64'h1000 + 64'(i0);
      end
      if (i1 < 4) begin
        req_op[1] = t_op1[i1]; req_op1[1] = t_a1[i1]; req_op2[1] = t_b1[i1]; req_id[1] = 64'h2000 + 64'(i1);
      end
      #1;
      if (resp_valid[0] && r0 < 4) begin
        check("rr_result0", resp_result, t_e0[r0]);
        check("rr_id0", resp_id, 64'h1000 + 64'(r0));
        $display("txn rr req0 #%0d result=%h id=%h", r0, resp_result, resp_id);
        r0++;
      end
      if (resp_valid[1] && r1 < 4) begin
        check("rr_result1", resp_result, t_e1[r1]);
        check("rr_id1", resp_id, 64'h2000 + 64'(r1));
        $display("txn rr req1 #%0d result=%h id=%h", r1, resp_result, resp_id);
        r1++;
      end
      if (req_grant[0]) begin
        check("rr_order", 0, 64'(g % 2)); i0++; g++;
      end else if (req_grant[1]) begin
        check("rr_order", 1, 64'(g % 2)); i1++; g++;
      end
      n++;
    end
    check("rr_complete", n < 3000, 1);
    check("rr_grants", g, 8);
    req_valid = '0; resp_ready = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
